// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
// Parametrised operand stack for the stack-architecture CPU. One stack
// operation is executed per clock: NOP, PUSH, POP, DUP, SWAP, OVER,
// REPLACE (ALU binary result) and CLEAR. The top two entries are held in
// registers so the ALU sees TOS/NOS with no extra cycle. Deeper entries
// live in an internal array indexed by the occupancy count. Illegal ops
// leave the stack untouched and set a sticky overflow/underflow flag.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   op_valid   in   execute op at this rising edge when 1
//   op         in   3-bit operation code
//   din        in   operand for PUSH / REPLACE
//   tos        out  top of stack (0 when empty)
//   nos        out  next on stack (0 when fewer than two entries)
//   count      out  number of entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky, op would have exceeded DEPTH
//   underflow  out  sticky, op needed more entries than present
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [DATA_WIDTH-1:0] nos,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_DUP     = 3'b011;
    localparam logic [2:0] OP_SWAP    = 3'b100;
    localparam logic [2:0] OP_OVER    = 3'b101;
    localparam logic [2:0] OP_REPLACE = 3'b110;
    localparam logic [2:0] OP_CLEAR   = 3'b111;

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO     = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] THREE   = CNT_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] tos_q, tos_d;
    logic [DATA_WIDTH-1:0] nos_q, nos_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    // Entries below NOS; entry k (k = 0 is the bottom of the stack) sits at
    // mem_q[k]. With E entries, NOS is logical entry E-2 and the third
    // entry is E-3.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  mem_we;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] third;
    logic                  is_full;
    logic                  ge1, ge2, ge3;

    assign is_full = (count_q == DEPTH_C);
    assign ge1     = (count_q >= ONE);
    assign ge2     = (count_q >= TWO);
    assign ge3     = (count_q >= THREE);

    // When an op grows the stack, old NOS sinks into the array at position
    // E-2. When an op shrinks it, the entry at E-3 surfaces as the new NOS.
    assign wr_idx = IDX_W'(count_q - TWO);
    assign rd_idx = IDX_W'(count_q - THREE);
    assign third  = ge3 ? mem_q[rd_idx] : '0;

    always_comb begin
        tos_d   = tos_q;
        nos_d   = nos_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mem_we  = 1'b0;

        if (op_valid) begin
            case (op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = ge2;
                        nos_d   = tos_q;
                        tos_d   = din;
                        count_d = count_q + ONE;
                    end
                end
                OP_POP: begin
                    if (!ge1) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = nos_q;
                        nos_d   = third;
                        count_d = count_q - ONE;
                    end
                end
                OP_DUP: begin
                    // Underflow is checked first so DUP on empty never
                    // reports overflow.
                    if (!ge1) begin
                        unf_d = 1'b1;
                    end else if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = ge2;
                        nos_d   = tos_q;
                        count_d = count_q + ONE;
                    end
                end
                OP_SWAP: begin
                    if (!ge2) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                end
                OP_OVER: begin
                    if (!ge2) begin
                        unf_d = 1'b1;
                    end else if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        tos_d   = nos_q;
                        nos_d   = tos_q;
                        count_d = count_q + ONE;
                    end
                end
                OP_REPLACE: begin
                    if (!ge2) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = din;
                        nos_d   = third;
                        count_d = count_q - ONE;
                    end
                end
                OP_CLEAR: begin
                    tos_d   = '0;
                    nos_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos_q   <= '0;
            nos_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; contents are meaningless until pushed again.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            mem_q[wr_idx] <= nos_q;
        end
    end

    assign tos       = tos_q;
    assign nos       = nos_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                           SWAP = 3'd4, OVER = 3'd5, REPL = 3'd6, CLR = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_valid;
    logic [2:0]    op;
    logic [DW-1:0] din;
    logic [DW-1:0] tos, nos;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    stack_unit #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .din(din),
        .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies one op at a falling edge, lets it take effect at the next
    // rising edge, then samples 1 time unit later.
    task automatic step(input logic [2:0] o, input logic [DW-1:0] d);
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        din      = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = NOP;
        din      = '0;
    endtask

    task automatic state(input string tag, input logic [DW-1:0] t, input logic [DW-1:0] n,
                         input int c, input logic o, input logic u);
        chk({tag, ".tos"},   32'(tos), 32'(t));
        chk({tag, ".nos"},   32'(nos), 32'(n));
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
        chk({tag, ".full"},  32'(full), 32'(c == DP));
        chk({tag, ".ovf"},   32'(overflow), 32'(o));
        chk({tag, ".unf"},   32'(underflow), 32'(u));
    endtask

    initial begin
        rst      = 1'b0;
        op_valid = 1'b0;
        op       = NOP;
        din      = '0;
        #12;
        state("reset0", 8'h00, 8'h00, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Fill to full, then overflow
        step(PUSH, 8'h11); state("push11", 8'h11, 8'h00, 1, 0, 0);
        step(PUSH, 8'h22); state("push22", 8'h22, 8'h11, 2, 0, 0);
        step(PUSH, 8'h33); state("push33", 8'h33, 8'h22, 3, 0, 0);
        step(PUSH, 8'h44); state("push44", 8'h44, 8'h33, 4, 0, 0);
        step(PUSH, 8'h55); state("push55ovf", 8'h44, 8'h33, 4, 1, 0);

        // Hold behaviour: NOP, and op_valid low with a PUSH opcode
        step(NOP, 8'h99); state("nop", 8'h44, 8'h33, 4, 1, 0);
        @(negedge clk);
        op = PUSH; din = 8'h99;
        @(posedge clk); #1;
        state("novalid", 8'h44, 8'h33, 4, 1, 0);
        op = NOP;

        // Drain; deeper entries surface from storage
        step(POP, 8'h00); state("pop1", 8'h33, 8'h22, 3, 1, 0);
        step(POP, 8'h00); state("pop2", 8'h22, 8'h11, 2, 1, 0);
        step(POP, 8'h00); state("pop3", 8'h11, 8'h00, 1, 1, 0);
        step(POP, 8'h00); state("pop4", 8'h00, 8'h00, 0, 1, 0);
        step(POP, 8'h00); state("pop5unf", 8'h00, 8'h00, 0, 1, 1);

        step(CLR, 8'h00); state("clear1", 8'h00, 8'h00, 0, 0, 0);

        // DUP on empty: underflow only
        step(DUP, 8'h00); state("dupempty", 8'h00, 8'h00, 0, 0, 1);
        step(CLR, 8'h00); state("clear2", 8'h00, 8'h00, 0, 0, 0);

        // REPLACE
        step(PUSH, 8'h05);
        step(PUSH, 8'h07);
        step(REPL, 8'h0C); state("repl", 8'h0C, 8'h00, 1, 0, 0);
        step(REPL, 8'h0D); state("replunf", 8'h0C, 8'h00, 1, 0, 1);
        step(CLR, 8'h00);

        // REPLACE with a third entry exposed from storage
        step(PUSH, 8'h01);
        step(PUSH, 8'h02);
        step(PUSH, 8'h03);
        step(REPL, 8'h09); state("repl3", 8'h09, 8'h01, 2, 0, 0);
        step(CLR, 8'h00);

        // SWAP / OVER / DUP
        step(PUSH, 8'hA1);
        step(PUSH, 8'hB2);
        step(SWAP, 8'h00); state("swap", 8'hA1, 8'hB2, 2, 0, 0);
        step(SWAP, 8'h00); state("swap2", 8'hB2, 8'hA1, 2, 0, 0);
        step(OVER, 8'h00); state("over", 8'hA1, 8'hB2, 3, 0, 0);
        step(DUP, 8'h00);  state("dup", 8'hA1, 8'hA1, 4, 0, 0);
        step(DUP, 8'h00);  state("dupfull", 8'hA1, 8'hA1, 4, 1, 0);
        step(OVER, 8'h00); state("overfull", 8'hA1, 8'hA1, 4, 1, 0);
        // Stack top-first is now A1, A1, B2, A1
        step(POP, 8'h00);  state("popd1", 8'hA1, 8'hB2, 3, 1, 0);
        step(POP, 8'h00);  state("popd2", 8'hB2, 8'hA1, 2, 1, 0);
        step(POP, 8'h00);
        step(SWAP, 8'h00); state("swapunf", 8'hA1, 8'h00, 1, 1, 1);

        // Both flags set: CLEAR drops them
        step(CLR, 8'h00);  state("clear3", 8'h00, 8'h00, 0, 0, 0);

        // Asynchronous reset while a PUSH is presented
        step(PUSH, 8'h66);
        step(PUSH, 8'h67);
        step(PUSH, 8'h68);
        step(PUSH, 8'h69);
        step(PUSH, 8'h6A); state("prerst", 8'h69, 8'h68, 4, 1, 0);
        @(negedge clk);
        op_valid = 1'b1; op = PUSH; din = 8'h77;
        #2;
        rst = 1'b0;
        #1;
        state("asyncrst", 8'h00, 8'h00, 0, 0, 0);
        @(posedge clk); #1;
        state("rstedge", 8'h00, 8'h00, 0, 0, 0);
        op_valid = 1'b0; op = NOP;
        @(negedge clk);
        rst = 1'b1;
        step(PUSH, 8'h42); state("afterrst", 8'h42, 8'h00, 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised operand stack for the stack-architecture CPU; replaces the fixed-size stack logic inside the cpu datapath.
- Executes one stack operation per clock: push, pop, dup, swap, over, binary-replace and clear.
- Top two entries (TOS/NOS) are always visible as registered outputs, so the ALU reads them with no extra cycle.
- Sticky overflow/underflow flags report illegal operations; an illegal operation never corrupts the stack.

Parameters:
- DATA_WIDTH, 8, width of each stack entry in bits.
- DEPTH, 16, maximum number of entries; any integer >= 2.
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- op_valid  input  1  when 1, op is executed at this rising edge.
- op  input  3  operation code (see Behaviour).
- din  input  DATA_WIDTH  operand for PUSH and REPLACE.
- tos  output  DATA_WIDTH  top of stack; 0 when count==0.
- nos  output  DATA_WIDTH  next on stack; 0 when count<2.
- count  output  CNT_WIDTH  current number of entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set by an operation that would exceed DEPTH.
- underflow  output  1  sticky; set by an operation needing more entries than present.

Behaviour:
Reset:
- rst low at any time asynchronously forces count=0, tos=0, nos=0, overflow=0, underflow=0, empty=1, full=0.
- Storage contents are don't-care after reset.
- Release is sampled at the next rising edge.
- Reset mid-operation discards that operation.

Timing:
- Single-cycle. An op accepted at edge N is fully reflected in tos/nos/count/flags after edge N.
- No back-pressure: the block accepts an op every cycle.
- op_valid=0, or op=NOP, holds all state.

Op codes, with legality and effect when legal (E = entries before the op):
- 000 NOP: no change.
- 001 PUSH: requires E<DEPTH. New tos=din, nos=old tos, count+1.
- 010 POP: requires E>=1. tos=old nos, nos=old third entry (0 if E<3), count-1.
- 011 DUP: requires 1<=E<DEPTH. tos=nos=old tos, count+1.
- 100 SWAP: requires E>=2. Exchanges tos and nos; count unchanged.
- 101 OVER: requires 2<=E<DEPTH. New tos=old nos, nos=old tos, count+1.
- 110 REPLACE (ALU binary result): requires E>=2. Removes two entries and pushes din. tos=din, nos=old third entry (0 if E<3), count-1.
- 111 CLEAR: always legal. count=0, tos=nos=0, overflow=underflow=0.

Error rules:
- An illegal op changes no stack state (count, tos, nos, stored entries) and sets exactly one flag.
- Underflow takes priority: if the op lacks required entries, set underflow; otherwise, if it would exceed DEPTH, set overflow. Example: DUP on empty sets underflow only.
- Flags stay set until CLEAR or reset. Legal ops never clear them.

Data and storage:
- Data is passed unmodified; no arithmetic on din.
- count never wraps: it saturates by rule, because illegal ops are rejected.
- empty and full are decoded from the registered count (combinational decode only).
- Entries below NOS live in an internal array indexed by count. When a POP or REPLACE exposes an entry, that entry appears on nos in the same cycle; no bubble.

Test Plan:
1. Reset with rst=0 after activity -> count=0, tos=0, nos=0, empty=1, both flags 0, asynchronously and before the next clock edge.
2. DEPTH=4, WIDTH=8: PUSH 0x11, 0x22, 0x33, 0x44 -> full=1, tos=0x44, nos=0x33. Fifth PUSH 0x55 -> overflow=1, tos=0x44, count=4 unchanged.
3. From stack [0x44,0x33,0x22,0x11] (top first): POP ×4 -> tos sequence 0x33, 0x22, 0x11, 0; nos reads 0 once count<2. Fifth POP -> underflow=1, count=0.
4. Push 0x05, 0x07, then REPLACE din=0x0C -> count=1, tos=0x0C, nos=0. A second REPLACE -> underflow=1, tos stays 0x0C.
5. Push 0xA1, 0xB2, then SWAP -> tos=0xA1, nos=0xB2. OVER -> tos=0xB2, count=3. DUP -> tos=nos=0xB2, count=4. DUP again at full -> overflow=1, no change.
6. With both flags set, CLEAR -> count=0, flags=0. Also assert rst low in the same cycle as op_valid=1/PUSH -> push discarded, count=0.
